key_debouncer: RTL and testbench

- Front-end conditioning stage for the board push-buttons (KEY[3:0], active-low, bouncing).
- Synchronises each raw key to CLOCK_50, filters contact bounce and emits a clean pressed level plus one-cycle press/release strobes.
- Feeds the LED/timer control logic directly, which must never sample raw KEY.
- One independent channel per key; all channels share one clock and one reset.

---
 rtl/key_pkg.sv | 17 +
 rtl/debounce_channel.sv | 145 ++++++++++++++
 rtl/key_debouncer.sv | 41 ++++
 tb/tb_key_debouncer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    localparam int unsigned CLK_HZ = 50000000;

    function automatic int unsigned cycles_from_ms(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key channel: 2-flop synchroniser, debounce FSM and counter.
// Auto-repeat on held keys is built only when KEY_REPEAT_EN is defined.
module debounce_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 8
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY_CYCLES = 20,
    parameter int unsigned REPEAT_RATE_CYCLES  = 6
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            ksync;
    deb_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d, accept_press;
    logic            release_q, release_d;

    // Raw key is active-low; ksync is 1 while pressed.
    assign ksync = ~sync_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_press = 1'b0;
        release_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ksync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CntW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!ksync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d      = PRESSED;
                    cnt_d        = '0;
                    accept_press = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            PRESSED: begin
                if (!ksync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CntW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (ksync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RepMax =
        (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned RepW = $clog2(RepMax + 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_phase_q, rep_phase_d;
    logic            rep_fire;

    // Counts only while the key stays in PRESSED; any exit clears it, so a
    // release glitch restarts the initial delay.
    always_comb begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_fire    = 1'b0;
        if (state_q == PRESSED && ksync) begin
            rep_phase_d = rep_phase_q;
            if (rep_cnt_q == (rep_phase_q ? RepW'(REPEAT_RATE_CYCLES - 1)
                                          : RepW'(REPEAT_DELAY_CYCLES - 1))) begin
                rep_fire    = 1'b1;
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + RepW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign press_d = accept_press | rep_fire;
`else
    assign press_d = accept_press;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low push-buttons into clean level and press/release strobes.
// Define KEY_REPEAT_EN to add auto-repeat press strobes on held keys.
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS              = 4,
    parameter int unsigned DEBOUNCE_CYCLES     = cycles_from_ms(20),
    parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cfg
        $error("key_debouncer: invalid cycle parameters");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
`endif
        ) u_ch (
            .clk_i     (CLOCK_50),
            .rst_ni    (RESET_N),
            .key_n_i   (KEY[i]),
            .level_o   (key_level[i]),
            .press_o   (key_press[i]),
            .release_o (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with DEBOUNCE_CYCLES=8.
// Strobes are checked against a scoreboard of expected (cycle, mask) events.
module tb_key_debouncer;

    localparam int unsigned NK  = 4;
    localparam int unsigned DEB = 8;
    localparam int unsigned RD  = 20;
    localparam int unsigned RR  = 6;
    localparam int          LAT = DEB + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] level, press, rel;

    key_debouncer #(
        .N_KEYS              (NK),
        .DEBOUNCE_CYCLES     (DEB),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_RATE_CYCLES  (RR)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .KEY         (key),
        .key_level   (level),
        .key_press   (press),
        .key_release (rel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        logic [3:0] press;
        logic [3:0] rel;
    } ev_t;

    typedef struct {
        logic [3:0] key;
        int         hold;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[$];
    ev_t  mon_ev;
    int   errors = 0;
    int   checks = 0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input logic [3:0] p, input logic [3:0] r);
        ev_t e;
        e.cyc   = at;
        e.press = p;
        e.rel   = r;
        exp_q.push_back(e);
    endtask

    task automatic add(input logic [3:0] k, input int h, input logic [3:0] p,
                       input logic [3:0] r, input logic [3:0] l);
        vec_t v;
        v.key   = k;
        v.hold  = h;
        v.press = p;
        v.rel   = r;
        v.level = l;
        vecs.push_back(v);
    endtask

    // Called just after a posedge; returns just after the posedge ending the step.
    task automatic apply(input vec_t v);
        key = v.key;
        if ((v.press | v.rel) != 4'b0000) expect_ev(cyc + LAT, v.press, v.rel);
        repeat (v.hold) @(negedge clk);
        check4("level_end_of_step", level, v.level);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_strobe: strobe absent, required press=%b release=%b at cycle %0d",
                     mon_ev.press, mon_ev.rel, mon_ev.cyc);
        end
        if (rst_n && (press | rel) != 4'b0000) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got press=%b release=%b at cycle %0d, required none",
                         press, rel, cyc);
            end else begin
                mon_ev = exp_q.pop_front();
                check4("press_strobe", press, mon_ev.press);
                check4("release_strobe", rel, mon_ev.rel);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) begin
            @(negedge clk);
            check4("reset_level", level, 4'b0000);
            check4("reset_press", press, 4'b0000);
            check4("reset_release", rel, 4'b0000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        add(4'b1111, 5, 4'b0000, 4'b0000, 4'b0000);
        // Clean press and release on KEY[1]
        add(4'b1101, 30, 4'b0010, 4'b0000, 4'b0010);
        add(4'b1111, 20, 4'b0000, 4'b0010, 4'b0000);
        // Bounce on KEY[0]: toggle every 3 cycles, then settle low
        for (int i = 0; i < 14; i++)
            add((i % 2 == 0) ? 4'b1110 : 4'b1111, 3, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 20, 4'b0001, 4'b0000, 4'b0001);
        add(4'b1111, 20, 4'b0000, 4'b0001, 4'b0000);
        // KEY[2] with a short release glitch, then a real release
        add(4'b1011, 20, 4'b0100, 4'b0000, 4'b0100);
        add(4'b1111, 5, 4'b0000, 4'b0000, 4'b0100);
        add(4'b1011, 15, 4'b0000, 4'b0000, 4'b0100);
        add(4'b1111, 12, 4'b0000, 4'b0100, 4'b0000);
        add(4'b1111, 5, 4'b0000, 4'b0000, 4'b0000);
        // All keys together
        add(4'b0000, 20, 4'b1111, 4'b0000, 4'b1111);
        add(4'b1111, 20, 4'b0000, 4'b1111, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset while KEY[1] sits in PRESS_WAIT; key stays held through reset
        key = 4'b1101;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check4("midreset_level", level, 4'b0000);
            check4("midreset_press", press, 4'b0000);
            check4("midreset_release", rel, 4'b0000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_ev(cyc + LAT, 4'b0010, 4'b0000);
        repeat (12) @(negedge clk);
        check4("held_through_reset_level", level, 4'b0010);
        @(posedge clk);
        #1;
        vecs.delete();
        add(4'b1111, 12, 4'b0000, 4'b0010, 4'b0000);
        add(4'b1111, 5, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

`ifdef KEY_REPEAT_EN
        // Auto-repeat: accepted press, +20, then every 6 cycles until release
        begin
            int e;
            e   = cyc;
            key = 4'b1110;
            expect_ev(e + LAT, 4'b0001, 4'b0000);
            for (int t = LAT + RD; t <= 60; t += RR) expect_ev(e + t, 4'b0001, 4'b0000);
            repeat (60) @(negedge clk);
            check4("repeat_held_level", level, 4'b0001);
            @(posedge clk);
            #1;
            key = 4'b1111;
            expect_ev(cyc + LAT, 4'b0000, 4'b0001);
            repeat (20) @(negedge clk);
            check4("repeat_release_level", level, 4'b0000);
        end
`endif

        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) begin
            mon_ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL pending_strobe: strobe absent, required press=%b release=%b at cycle %0d",
                     mon_ev.press, mon_ev.rel, mon_ev.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
